// File: rtl/id_ex_stage.sv
// id_ex_stage
//
// ID/EX pipeline register of the five-stage RV32I core. Carries one decoded
// instruction from decode into execute, detects load-use hazards and inserts
// a single bubble for them, kills the ID instruction on a taken branch/jump
// (flush), and freezes completely on a downstream memory stall. The latched
// register specifiers feed the forwarding unit, whose select/value outputs
// are merged here with the latched register-file data to form the final EX
// operands. Two saturating counters report bubbles and flushes.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   id_valid, id_pc, id_rs0/1,  decoded instruction from the ID stage
//   id_rd, id_rdata0/1, id_imm,
//   id_alu_op, id_regwrite,
//   id_memread, id_memwrite,
//   id_branch
//   flush                       taken branch/jump resolved in EX
//   mem_stall                   downstream freeze, hold everything
//   fwd_sel0/1, fwd_reg0/1      forwarding unit selects and values
//   id_stall                    hold PC and IF/ID this cycle
//   ex_*                        registered instruction presented to EX
//   ex_op0, ex_op1              final EX operands after forwarding
//   bubble_cnt, flush_cnt       saturating performance counters

module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic [4:0]       id_rs0,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rd,
  input  logic [31:0]      id_rdata0,
  input  logic [31:0]      id_rdata1,
  input  logic [31:0]      id_imm,
  input  logic [3:0]       id_alu_op,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_branch,
  input  logic             flush,
  input  logic             mem_stall,
  input  logic             fwd_sel0,
  input  logic             fwd_sel1,
  input  logic [31:0]      fwd_reg0,
  input  logic [31:0]      fwd_reg1,
  output logic             id_stall,
  output logic             ex_valid,
  output logic [31:0]      ex_pc,
  output logic [31:0]      ex_imm,
  output logic [4:0]       ex_rs0,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rd,
  output logic [3:0]       ex_alu_op,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_branch,
  output logic [31:0]      ex_op0,
  output logic [31:0]      ex_op1,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic        load_use;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  // A load in EX whose destination is read by the instruction in ID cannot
  // be forwarded in time; x0 is never a real dependency.
  always_comb begin
    load_use = id_valid & ex_valid & ex_memread & (ex_rd != 5'd0) &
               ((ex_rd == id_rs0) | (ex_rd == id_rs1));
    // A flush kills the consumer anyway, so there is nothing to hold.
    id_stall = mem_stall | (load_use & ~flush);
  end

  // Valid and control bits: cleared by both kinds of bubble, otherwise
  // captured already gated by id_valid so EX never sees stray enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_branch   <= 1'b0;
    end else if (mem_stall) begin
      ex_valid    <= ex_valid;
    end else if (flush || load_use) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_branch   <= 1'b0;
    end else begin
      ex_valid    <= id_valid;
      ex_regwrite <= id_regwrite & id_valid;
      ex_memread  <= id_memread  & id_valid;
      ex_memwrite <= id_memwrite & id_valid;
      ex_branch   <= id_branch   & id_valid;
    end
  end

  // Datapath fields only move on a normal capture; during bubbles they keep
  // their old (don't-care) contents to avoid needless toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_pc     <= '0;
      ex_imm    <= '0;
      ex_rs0    <= '0;
      ex_rs1    <= '0;
      ex_rd     <= '0;
      ex_alu_op <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else if (!mem_stall && !flush && !load_use) begin
      ex_pc     <= id_pc;
      ex_imm    <= id_imm;
      ex_rs0    <= id_rs0;
      ex_rs1    <= id_rs1;
      ex_rd     <= id_rd;
      ex_alu_op <= id_alu_op;
      rdata0_q  <= id_rdata0;
      rdata1_q  <= id_rdata1;
    end
  end

  // Saturating counters; a flush takes precedence over a coincident hazard
  // so only one of them counts per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (!mem_stall) begin
      if (flush) begin
        if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      end else if (load_use) begin
        if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end

  // Final operands: forwarded value wins over the latched register data.
  always_comb begin
    ex_op0 = fwd_sel0 ? fwd_reg0 : rdata0_q;
    ex_op1 = fwd_sel1 ? fwd_reg1 : rdata1_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
//
// Directed bench for id_ex_stage (CNT_W = 4 so saturation is reachable).
// A behavioural reference of the stage, kept as plain variables, is updated
// on every clock edge and compared against the DUT on every falling edge;
// directed scenarios add hand-computed literal checks.

module tb_id_ex_stage;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [31:0]      id_pc;
  logic [4:0]       id_rs0, id_rs1, id_rd;
  logic [31:0]      id_rdata0, id_rdata1, id_imm;
  logic [3:0]       id_alu_op;
  logic             id_regwrite, id_memread, id_memwrite, id_branch;
  logic             flush, mem_stall;
  logic             fwd_sel0, fwd_sel1;
  logic [31:0]      fwd_reg0, fwd_reg1;
  logic             id_stall, ex_valid;
  logic [31:0]      ex_pc, ex_imm;
  logic [4:0]       ex_rs0, ex_rs1, ex_rd;
  logic [3:0]       ex_alu_op;
  logic             ex_regwrite, ex_memread, ex_memwrite, ex_branch;
  logic [31:0]      ex_op0, ex_op1;
  logic [CNT_W-1:0] bubble_cnt, flush_cnt;

  int n_vec = 0;
  int n_bad = 0;

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs0(id_rs0), .id_rs1(id_rs1), .id_rd(id_rd),
    .id_rdata0(id_rdata0), .id_rdata1(id_rdata1), .id_imm(id_imm),
    .id_alu_op(id_alu_op),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_branch(id_branch),
    .flush(flush), .mem_stall(mem_stall),
    .fwd_sel0(fwd_sel0), .fwd_sel1(fwd_sel1),
    .fwd_reg0(fwd_reg0), .fwd_reg1(fwd_reg1),
    .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs0(ex_rs0), .ex_rs1(ex_rs1), .ex_rd(ex_rd),
    .ex_alu_op(ex_alu_op),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
    .ex_op0(ex_op0), .ex_op1(ex_op1),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Reference state: what the EX slot must hold, in plain terms.
  logic        m_valid;
  logic [31:0] m_pc, m_imm, m_rdata0, m_rdata1;
  logic [4:0]  m_rs0, m_rs1, m_rd;
  logic [3:0]  m_op;
  logic [3:0]  m_ctrl;   // {regwrite, memread, memwrite, branch}
  int          m_bubbles, m_flushes;

  function automatic logic m_hazard();
    // The ID instruction reads the register an EX load is about to write.
    return id_valid && m_valid && m_ctrl[2] && m_rd != 0 &&
           (m_rd == id_rs0 || m_rd == id_rs1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_pc = 0; m_imm = 0; m_rdata0 = 0; m_rdata1 = 0;
      m_rs0 = 0; m_rs1 = 0; m_rd = 0; m_op = 0; m_ctrl = 0;
      m_bubbles = 0; m_flushes = 0;
    end else if (mem_stall) begin
      m_valid = m_valid;
    end else if (flush) begin
      m_valid = 0; m_ctrl = 0;
      if (m_flushes < CMAX) m_flushes++;
    end else if (m_hazard()) begin
      m_valid = 0; m_ctrl = 0;
      if (m_bubbles < CMAX) m_bubbles++;
    end else begin
      m_valid = id_valid;
      m_pc = id_pc; m_imm = id_imm; m_rs0 = id_rs0; m_rs1 = id_rs1;
      m_rd = id_rd; m_op = id_alu_op; m_rdata0 = id_rdata0; m_rdata1 = id_rdata1;
      m_ctrl = id_valid ? {id_regwrite, id_memread, id_memwrite, id_branch} : 4'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the reference.
  always @(negedge clk) begin
    checkOutput("m_ex_valid", 32'(ex_valid), 32'(m_valid));
    checkOutput("m_ctrl", 32'({ex_regwrite, ex_memread, ex_memwrite, ex_branch}),
                32'(m_ctrl));
    checkOutput("m_bubble_cnt", 32'(bubble_cnt), 32'(m_bubbles));
    checkOutput("m_flush_cnt", 32'(flush_cnt), 32'(m_flushes));
    checkOutput("m_id_stall", 32'(id_stall),
                32'(mem_stall || (m_hazard() && !flush)));
    if (m_valid) begin
      checkOutput("m_ex_pc", ex_pc, m_pc);
      checkOutput("m_ex_imm", ex_imm, m_imm);
      checkOutput("m_ex_regs", 32'({ex_rs0, ex_rs1, ex_rd}), 32'({m_rs0, m_rs1, m_rd}));
      checkOutput("m_ex_alu_op", 32'(ex_alu_op), 32'(m_op));
      checkOutput("m_ex_op0", ex_op0, fwd_sel0 ? fwd_reg0 : m_rdata0);
      checkOutput("m_ex_op1", ex_op1, fwd_sel1 ? fwd_reg1 : m_rdata1);
    end
  end

  // ctrl = {regwrite, memread, memwrite, branch}
  task automatic applyStimulus(input logic v, input logic [31:0] pc,
                               input logic [4:0] rs0, input logic [4:0] rs1,
                               input logic [4:0] rd, input logic [31:0] rd0,
                               input logic [31:0] rd1, input logic [3:0] op,
                               input logic [3:0] ctrl);
    id_valid = v; id_pc = pc; id_rs0 = rs0; id_rs1 = rs1; id_rd = rd;
    id_rdata0 = rd0; id_rdata1 = rd1; id_imm = pc ^ 32'h0000_0F00;
    id_alu_op = op;
    {id_regwrite, id_memread, id_memwrite, id_branch} = ctrl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] held_pc;
    rst_n = 0; flush = 0; mem_stall = 0;
    fwd_sel0 = 0; fwd_sel1 = 0; fwd_reg0 = 0; fwd_reg1 = 0;
    applyStimulus(1, 32'h100, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 4'd2, 4'b1000);
    step(); step();
    checkOutput("reset_valid", 32'(ex_valid), 32'd0);
    checkOutput("reset_pc", ex_pc, 32'd0);
    rst_n = 1;
    step();
    checkOutput("first_pc", ex_pc, 32'h100);
    checkOutput("first_valid", 32'(ex_valid), 32'd1);

    // Load-use: lw x5, then add x6,x5,x1.
    applyStimulus(1, 32'h104, 5'd1, 5'd0, 5'd5, 32'h0, 32'h0, 4'd0, 4'b1100);
    step();
    applyStimulus(1, 32'h108, 5'd5, 5'd1, 5'd6, 32'h11, 32'h22, 4'd0, 4'b1000);
    #1 checkOutput("lu_stall", 32'(id_stall), 32'd1);
    step();
    checkOutput("lu_bubble_valid", 32'(ex_valid), 32'd0);
    checkOutput("lu_bubble_regwrite", 32'(ex_regwrite), 32'd0);
    checkOutput("lu_bubble_cnt", 32'(bubble_cnt), 32'd1);
    checkOutput("lu_stall_drop", 32'(id_stall), 32'd0);
    step();
    checkOutput("lu_add_pc", ex_pc, 32'h108);
    fwd_sel0 = 1; fwd_reg0 = 32'hDEADBEEF;
    #1 checkOutput("lu_fwd_op0", ex_op0, 32'hDEADBEEF);
    checkOutput("lu_op1", ex_op1, 32'h22);
    fwd_sel0 = 0;

    // lw x0 followed by a reader of x0: no hazard.
    applyStimulus(1, 32'h10C, 5'd2, 5'd0, 5'd0, 32'h0, 32'h0, 4'd0, 4'b0100);
    step();
    applyStimulus(1, 32'h110, 5'd0, 5'd4, 5'd9, 32'h0, 32'h44, 4'd3, 4'b1000);
    #1 checkOutput("x0_stall", 32'(id_stall), 32'd0);
    step();
    checkOutput("x0_pc", ex_pc, 32'h110);
    checkOutput("x0_bubbles", 32'(bubble_cnt), 32'd1);

    // Flush together with a load-use hazard.
    applyStimulus(1, 32'h114, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 4'd0, 4'b1100);
    step();
    applyStimulus(1, 32'h118, 5'd3, 5'd7, 5'd8, 32'h1, 32'h2, 4'd1, 4'b1011);
    flush = 1;
    #1 checkOutput("fl_stall", 32'(id_stall), 32'd0);
    step();
    flush = 0;
    checkOutput("fl_valid", 32'(ex_valid), 32'd0);
    checkOutput("fl_cnt", 32'(flush_cnt), 32'd1);
    checkOutput("fl_bubbles", 32'(bubble_cnt), 32'd1);

    // Invalid ID slot with control bits set must not leak into EX.
    applyStimulus(0, 32'h11A, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0, 4'd0, 4'b1111);
    step();
    checkOutput("inv_ctrl", 32'({ex_regwrite, ex_memread, ex_memwrite, ex_branch}), 32'd0);

    // Freeze with a pending flush.
    applyStimulus(1, 32'h11C, 5'd2, 5'd3, 5'd4, 32'h5, 32'h6, 4'd7, 4'b1001);
    step();
    mem_stall = 1; flush = 1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h200 + 32'(i * 4), 5'd4, 5'd4, 5'd1, 32'(i), 32'(i), 4'(i), 4'b1100);
      step();
      checkOutput("frz_pc", ex_pc, 32'h11C);
      checkOutput("frz_valid", 32'(ex_valid), 32'd1);
      checkOutput("frz_flush_cnt", 32'(flush_cnt), 32'd1);
    end
    mem_stall = 0;
    step();
    flush = 0;
    checkOutput("frz_rel_valid", 32'(ex_valid), 32'd0);
    checkOutput("frz_rel_cnt", 32'(flush_cnt), 32'd2);
    step();
    checkOutput("frz_once_cnt", 32'(flush_cnt), 32'd2);
    checkOutput("frz_capture", 32'(ex_valid), 32'd1);

    // Reset while frozen discards the held instruction.
    mem_stall = 1;
    step();
    rst_n = 0;
    #1 checkOutput("rst_stall_valid", 32'(ex_valid), 32'd0);
    checkOutput("rst_stall_pc", ex_pc, 32'd0);
    checkOutput("rst_stall_idstall", 32'(id_stall), 32'd1);
    checkOutput("rst_stall_fcnt", 32'(flush_cnt), 32'd0);
    #2 rst_n = 1;
    mem_stall = 0;
    applyStimulus(1, 32'h300, 5'd1, 5'd2, 5'd3, 32'h7, 32'h8, 4'd1, 4'b1000);
    step();
    checkOutput("rst_new_pc", ex_pc, 32'h300);

    // Twenty load-use events saturate the 4-bit bubble counter.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 32'h400 + 32'(i * 8), 5'd1, 5'd2, 5'd3, 32'h0, 32'h0, 4'd0, 4'b1100);
      step();
      applyStimulus(1, 32'h404 + 32'(i * 8), 5'd3, 5'd9, 5'd10, 32'h1, 32'h2, 4'd0, 4'b1000);
      step();
      step();
    end
    checkOutput("sat_bubbles", 32'(bubble_cnt), 32'd15);
    step();
    checkOutput("sat_hold", 32'(bubble_cnt), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the five-stage RV32I core, carrying one decoded instruction from decode into execute. It detects load-use hazards, inserts bubbles, handles flush and stall, and exposes registered `rs0`/`rs1`/`rd` to the forwarding unit. It combines that unit's `sel`/`reg` outputs with the latched register-file data to produce the final EX operands. Two saturating counters report bubbles and flushes for performance debug.

## Interface
- `CNT_W`, default 16: width of the bubble and flush counters.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `id_valid`  in  1: the ID slot holds a real instruction.
- `id_pc`  in  32: PC of the ID instruction.
- `id_rs0`, `id_rs1`, `id_rd`  in  5 each: register specifiers.
- `id_rdata0`, `id_rdata1`  in  32: register-file read data. The register file is write-through, so a same-cycle WB write is already reflected here.
- `id_imm`  in  32: immediate.
- `id_alu_op`  in  4: ALU operation.
- `id_regwrite`, `id_memread`, `id_memwrite`, `id_branch`  in  1 each: control bits.
- `flush`  in  1: branch/jump resolved taken in EX; kill the ID instruction.
- `mem_stall`  in  1: downstream freeze; hold all state.
- `fwd_sel0`, `fwd_sel1`  in  1: forward enables from the forwarding unit, computed on `ex_rs0`/`ex_rs1`.
- `fwd_reg0`, `fwd_reg1`  in  32: forwarded values.
- `id_stall`  out  1: hold PC and IF/ID this cycle.
- `ex_valid`  out  1: the EX slot holds a real instruction.
- `ex_pc`, `ex_imm`  out  32.
- `ex_rs0`, `ex_rs1`, `ex_rd`  out  5: feed the forwarding unit.
- `ex_alu_op`  out  4.
- `ex_regwrite`, `ex_memread`, `ex_memwrite`, `ex_branch`  out  1: already gated by `ex_valid`.
- `ex_op0`, `ex_op1`  out  32: final EX operands.
- `bubble_cnt`, `flush_cnt`  out  `CNT_W`.

## Operation
- **Load-use hazard.** `load_use` is asserted when all of the following hold:
  - `id_valid & ex_valid & ex_memread`
  - `ex_rd != 0`
  - `ex_rd == id_rs0` or `ex_rd == id_rs1`
- **`id_stall`** = `mem_stall | (load_use & ~flush)`. It is combinational.
- **Per-edge update, highest priority first:**
  1. **`mem_stall`:** every register holds, including the counters. `flush` and `load_use` are ignored; their sources hold them until the stall releases.
  2. **`flush`:** `ex_valid` ← 0, all control bits ← 0, `flush_cnt` += 1.
  3. **`load_use`:** `ex_valid` ← 0, all control bits ← 0, `bubble_cnt` += 1. Datapath fields hold their previous values (don't-care).
  4. **Otherwise:** capture all `id_*` fields. `ex_valid` ← `id_valid`, and each control bit ← `id_x & id_valid`.
- **Counters:** saturate at all-ones and never wrap.
- **Operands:** `ex_op0 = fwd_sel0 ? fwd_reg0 : rdata0_q`, and likewise `ex_op1` from `fwd_sel1`/`fwd_reg1`. Purely combinational, with no extra latency.
- **Forwarding on bubbles:** when `ex_valid` = 0, the forwarding selects are still honoured. Output values are don't-care, but control outputs are 0.
- **`x0` handling:** `rs` = 0 relies on the forwarding unit never selecting `x0`. The register file returns 0 for `x0`.

## Timing
- **Latency:** one cycle from ID capture to the EX outputs.
- **Load-use bubble:** exactly one. The load moves to MEM while the consumer is held in ID. On the next edge the consumer enters EX with the load in WB, and the WB forward supplies the data.
- **`id_stall` vs `flush`:** `id_stall` is valid in the same cycle as the hazard. It deasserts the cycle after the bubble enters EX, because `ex_memread` is then 0.
- **Reset (asynchronous, immediate on `rst_n` low):**
  - `ex_valid`, all control outputs, `ex_pc`, `ex_imm`, `ex_rs0`/`ex_rs1`/`ex_rd`, `ex_alu_op`, latched rdata and both counters = 0.
  - `id_stall` is then driven by `mem_stall` alone.
  - Reset mid-stall discards the held instruction.
- **Simultaneous `flush` and `load_use`:** a flush bubble; only `flush_cnt` increments and `id_stall` = 0.
- **`mem_stall` released with `flush` held:** the flush applies on the first unstalled edge.

## Test plan
- **Reset:** drive `rst_n` = 0 mid-cycle with `id_valid` = 1 → all outputs 0 immediately. After release, the first edge captures `id_pc` = `0x100`, giving `ex_pc` = `0x100` and `ex_valid` = 1.
- **Load-use:** `lw x5` in EX with `ex_memread` = 1, `ex_rd` = 5, and ID `add x6,x5,x1` (`id_rs0` = 5):
  - `id_stall` = 1 for one cycle, then EX shows a bubble (`ex_valid` = 0, `ex_regwrite` = 0) and `bubble_cnt` = 1.
  - The next edge captures the add.
  - With `fwd_sel0` = 1 and `fwd_reg0` = `0xDEADBEEF`, `ex_op0` = `0xDEADBEEF`.
- **No hazard on `x0`:** `lw x0` in EX with `id_rs0` = 0 → `id_stall` = 0 and no bubble.
- **Flush priority:** `flush` and `load_use` asserted together → `ex_valid` = 0, `flush_cnt` += 1, `bubble_cnt` unchanged, `id_stall` = 0.
- **Freeze:** `mem_stall` = 1 for 3 cycles with changing `id_*` and `flush` = 1 → EX outputs and counters stable. After release, the flush bubble is inserted once.
- **Saturation:** with `CNT_W` = 4, apply 20 load-use events → `bubble_cnt` = 15 and holds there.
